ctrl_result_drain: RTL
======================

CTRL_RESULT_DRAIN -- requirements
Module: ctrl_result_drain

Interface
REQ-001 SHALL have parameter LANES, default 32, number of result words per pass.
REQ-002 SHALL have parameter DW, default 32, width of one result word.
REQ-003 SHALL have input clk, 1 bit: rising-edge clock.
REQ-004 SHALL have input rstn, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input end_signal, 1 bit: pass-complete level from the state-count controller; held high until controller reset.
REQ-006 SHALL have input res_data, LANES*DW bits: parallel pipe results; lane i occupies bits [i*DW +: DW]; stable while end_signal is high.
REQ-007 SHALL have input clr, 1 bit: synchronous abort and flag clear.
REQ-008 SHALL have output out_data, DW bits: current serialized result word.
REQ-009 SHALL have output out_idx, clog2(LANES) bits: lane index of out_data.
REQ-010 SHALL have output out_valid, 1 bit: out_data is valid.
REQ-011 SHALL have input out_ready, 1 bit: downstream accepts the word.
REQ-012 SHALL have output out_last, 1 bit: high with out_valid when out_idx equals LANES-1.
REQ-013 SHALL have output busy, 1 bit: high in DRAIN.
REQ-014 SHALL have output done, 1 bit: single-cycle pulse after the last word is accepted.
REQ-015 SHALL have output overrun, 1 bit: sticky; a capture was refused.

Function
REQ-016 SHALL register end_signal and detect its rising edge (end_d low, end_signal high).
REQ-017 SHALL use two states: IDLE and DRAIN.
REQ-018 In IDLE, on a rising edge, SHALL copy all of res_data into a LANES x DW shadow buffer, set idx to 0 and enter DRAIN on the same clock edge.
REQ-019 In DRAIN, SHALL hold out_valid high, drive out_data from shadow[idx] and drive out_idx from idx.
REQ-020 A transfer SHALL occur when out_valid and out_ready are both high on a rising clk edge; SHALL then increment idx.
REQ-021 SHALL keep out_data, out_idx and out_valid stable while out_valid is high and out_ready is low.
REQ-022 On a transfer with idx equal to LANES-1, SHALL return to IDLE, reset idx to 0 and pulse done for exactly the next cycle.
REQ-023 SHALL drive out_valid low in IDLE; out_data is don't-care there and SHALL be driven as 0.
REQ-024 A rising edge of end_signal in DRAIN SHALL NOT update the shadow buffer and SHALL set overrun.
REQ-025 A rising edge in the same cycle as the final transfer SHALL also count as overrun; SHALL NOT be captured.
REQ-026 clr high SHALL force IDLE, set idx to 0, clear overrun and suppress done, taking priority over all other events in that cycle.
REQ-027 A drain with out_ready held high SHALL complete in exactly LANES cycles from entering DRAIN; done SHALL assert in cycle LANES+1.
REQ-028 idx SHALL never exceed LANES-1; there is no wrap-around within one drain.

Reset
REQ-029 rstn low SHALL asynchronously force IDLE, idx to 0, end_d to 0, and out_valid, out_last, busy, done, overrun and out_data to 0.
REQ-030 The shadow buffer need not be reset.
REQ-031 If end_signal is already high when rstn deasserts, SHALL NOT capture until end_signal has been seen low and then rises again.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold the LANES and DW defaults, the IDX_W = clog2(LANES) constant and the drain state enum (IDLE, DRAIN).
REQ-033 Edge detection SHALL be a sub-module named rise_detect (clk, rstn, d, rise).
REQ-034 The shadow buffer SHALL be flops, not an inferred RAM; single read port muxed by idx.

Verification
REQ-035 Load res_data with lane i = i+100, raise end_signal, hold out_ready=1 -> words 100..131 on consecutive cycles, out_idx 0..31, out_last only on 131, done one cycle later.
REQ-036 Same data, out_ready toggling 1,0,1,0 -> all 32 words in order, each held unchanged while stalled, no duplicates or drops.
REQ-037 Drop end_signal and raise it again while out_idx=5 -> overrun=1, drain continues with original data, no second drain.
REQ-038 Assert clr at out_idx=10 -> next cycle out_valid=0, busy=0, overrun=0, no done pulse.
REQ-039 Pulse rstn low mid-drain with end_signal held high -> all outputs 0; no new drain until end_signal falls and rises again.
REQ-040 Set LANES=4 and DW=8 -> exactly 4 words, out_idx 0..3 (2 bits), done after 4 accepted transfers.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared defaults, index width and drain state encoding for the
//               result-drain path.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam int LANES_DEFAULT = 32;
  localparam int DW_DEFAULT    = 32;
  localparam int IDX_W         = $clog2(LANES_DEFAULT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Rising-edge detector on a level input. The edge only counts
//               once the input has been seen low since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic r_d_q;
  logic r_armed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d_q   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_d_q <= d;
      // A level already high when reset is released must not look like an edge.
      if (!d) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign rise = d & ~r_d_q & r_armed;

endmodule
`default_nettype wire

// File: rtl/ctrl_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_result_drain
// Description : Captures LANES parallel results on the controller's end edge
//               and serializes them one word per accepted ready/valid transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_result_drain
  import ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     end_signal,
  input  logic [LANES*DW-1:0]      res_data,
  input  logic                     clr,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(LANES)-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int            IW         = $clog2(LANES);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(LANES - 1);

  drain_state_e  r_state;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_out_data;
  logic          r_valid;
  logic          r_last;
  logic          r_done;
  logic          r_overrun;
  logic [DW-1:0] r_shadow [LANES];

  logic          w_rise;
  logic          w_capture;
  logic [IW-1:0] w_idx_inc;
  logic [DW-1:0] w_next_word;

  rise_detect u_rise_detect (
    .clk  (clk),
    .rstn (rstn),
    .d    (end_signal),
    .rise (w_rise)
  );

  assign w_capture   = (r_state == IDLE) & w_rise & ~clr;
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_next_word = r_shadow[w_idx_inc];

  // Shadow buffer is plain flops with one muxed read port; contents are
  // meaningless until the first capture, so no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < LANES; i++) begin
        r_shadow[i] <= res_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_out_data <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_state    <= IDLE;
        r_idx      <= '0;
        r_out_data <= '0;
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        // An edge arriving while still draining, even on the final beat, is refused.
        if (w_rise && (r_state == DRAIN)) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (w_capture) begin
              r_state    <= DRAIN;
              r_idx      <= '0;
              r_out_data <= res_data[DW-1:0];
              r_valid    <= 1'b1;
              r_last     <= 1'b0;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (r_idx == C_LAST_IDX) begin
                r_state    <= IDLE;
                r_idx      <= '0;
                r_out_data <= '0;
                r_valid    <= 1'b0;
                r_last     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_idx      <= w_idx_inc;
                r_out_data <= w_next_word;
                r_last     <= (w_idx_inc == C_LAST_IDX);
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state == DRAIN);
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire
